parking_lot_model: RTL

// - Cycle-accurate model of the physical lot: cars, entrance/exit lanes and spot sensors.
// - Responder to the lot controller: consumes opengate_enter/opengate_exit.
// - Drives the controller's enter, exit and park[] sensor inputs.
// - Synthesizable, so the controller can run closed-loop on the board (keys = car events).

---
 rtl/parking_pkg.sv | 16 +
 rtl/parking_lot_model_if.sv | 30 +++
 rtl/parking_gate_lane.sv | 78 +++++++
 rtl/parking_lot_model.sv | 120 ++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default lot geometry/timing for the parking lot model and
// the controller bench.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PASS
  } lane_state_t;

  localparam int unsigned DEFAULT_NUM_SPOTS      = 3;
  localparam int unsigned DEFAULT_PASS_CYCLES    = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 8;
  localparam int unsigned DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/parking_lot_model_if.sv
// Controller <-> lot link: gate commands toward the lot, sensors toward the controller.
interface parking_lot_model_if
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SPOTS = DEFAULT_NUM_SPOTS
);

  logic                 opengate_enter;
  logic                 opengate_exit;
  logic                 enter;
  logic                 exit;
  logic [NUM_SPOTS-1:0] park;

  modport master (
    output opengate_enter,
    output opengate_exit,
    input  enter,
    input  exit,
    input  park
  );

  modport slave (
    input  opengate_enter,
    input  opengate_exit,
    output enter,
    output exit,
    output park
  );

endinterface

// File: rtl/parking_gate_lane.sv
// One gate lane: a car waits at the gate, drives through once it opens, and
// (optionally) gives up after waiting too long.
module parking_gate_lane
  import parking_pkg::*;
#(
  parameter int unsigned PASS_CYCLES    = DEFAULT_PASS_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gate,
  output logic sensor,
  output logic idle,
  output logic done,
  output logic abort
);

  localparam int unsigned TMAX = (PASS_CYCLES > TIMEOUT_CYCLES) ? PASS_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  lane_state_t   state;
  logic [TW-1:0] timer;

  // done/abort decode the current state so the top can act on the same edge
  // as the lane's own transition.
  always_comb begin
    idle  = (state == IDLE);
    done  = (state == PASS) && (timer == TW'(PASS_CYCLES - 1));
    abort = TIMEOUT_EN && (state == WAIT) && !gate && (timer == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      sensor <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state  <= WAIT;
            timer  <= '0;
            sensor <= 1'b1;
          end
        end
        WAIT: begin
          if (gate) begin
            state  <= PASS;
            timer  <= '0;
            sensor <= 1'b0;
          end else if (abort) begin
            state  <= IDLE;
            timer  <= '0;
            sensor <= 1'b0;
          end else if (TIMEOUT_EN) begin
            timer <= timer + TW'(1);
          end
        end
        PASS: begin
          if (done) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          sensor <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_model.sv
// Cycle-accurate parking lot (cars, entrance/exit lanes, spot sensors) driven by
// the lot controller's gate commands. Optional statistics: define PARKING_STATS_EN.
module parking_lot_model
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SPOTS      = DEFAULT_NUM_SPOTS,
  parameter int unsigned PASS_CYCLES    = DEFAULT_PASS_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         car_arrive,
  input  logic                         car_leave_req,
  input  logic [$clog2(NUM_SPOTS)-1:0] leave_idx,
  parking_lot_model_if.slave           lot,
  output logic                         balk,
  output logic                         overfill_err
`ifdef PARKING_STATS_EN
  ,
  output logic [CNT_W-1:0]             entries,
  output logic [CNT_W-1:0]             exits,
  output logic [CNT_W-1:0]             balks
`endif
);

  logic [NUM_SPOTS-1:0] park_q;
  logic [NUM_SPOTS-1:0] free;
  logic [NUM_SPOTS-1:0] set_mask;
  logic [NUM_SPOTS-1:0] sel_mask;
  logic [NUM_SPOTS-1:0] clr_mask;
  logic                 full;
  logic                 arrive_ok;
  logic                 leave_ok;

  logic ent_sensor, ent_idle, ent_done, ent_abort;
  logic ex_sensor,  ex_idle,  ex_done,  ex_abort;

  // Allocation looks only at the registered park vector, so a spot freed by
  // an exit acceptance in the same cycle is not reused until the next cycle.
  always_comb begin
    free      = ~park_q;
    set_mask  = free & (~free + NUM_SPOTS'(1));
    full      = &park_q;
    sel_mask  = NUM_SPOTS'(1) << leave_idx;
    arrive_ok = car_arrive && ent_idle;
    leave_ok  = car_leave_req && ex_idle && |(park_q & sel_mask);
    clr_mask  = leave_ok ? sel_mask : '0;
  end

  parking_gate_lane #(
    .PASS_CYCLES    (PASS_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_EN     (1'b1)
  ) u_entrance (
    .clk    (clk),
    .reset  (reset),
    .req    (arrive_ok),
    .gate   (lot.opengate_enter),
    .sensor (ent_sensor),
    .idle   (ent_idle),
    .done   (ent_done),
    .abort  (ent_abort)
  );

  parking_gate_lane #(
    .PASS_CYCLES    (PASS_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_EN     (1'b0)
  ) u_exit (
    .clk    (clk),
    .reset  (reset),
    .req    (leave_ok),
    .gate   (lot.opengate_exit),
    .sensor (ex_sensor),
    .idle   (ex_idle),
    .done   (ex_done),
    .abort  (ex_abort)
  );

  assign lot.enter = ent_sensor;
  assign lot.exit  = ex_sensor;
  assign lot.park  = park_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      park_q       <= '0;
      balk         <= 1'b0;
      overfill_err <= 1'b0;
    end else begin
      // The exit lane is built without a timeout, so its abort is always low.
      balk   <= ent_abort | ex_abort;
      park_q <= (park_q | (ent_done ? set_mask : '0)) & ~clr_mask;
      if (ent_done && full) begin
        overfill_err <= 1'b1;
      end
    end
  end

`ifdef PARKING_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '0;
      exits   <= '0;
      balks   <= '0;
    end else begin
      if (ent_done && !full) begin
        entries <= entries + CNT_W'(1);
      end
      if (ex_done) begin
        exits <= exits + CNT_W'(1);
      end
      if (ent_abort) begin
        balks <= balks + CNT_W'(1);
      end
    end
  end
`endif

endmodule
